thermo_sequencer: RTL

Closed-loop actuator sequencer for the temperature-control datapath. Samples the 8-bit temperature reading and drives the mutually exclusive Heat and Cool actuators with hysteresis, minimum run time and a dead-time interlock. Thresholds are runtime-programmable through a single-cycle write port. Sits between the temperature sensor interface and the heater/cooler drivers, and replaces direct combinational threshold decode.

---
 rtl/thermo_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/thermo_sequencer.sv
// thermo_sequencer: heat/cool actuator sequencer with hysteresis, minimum on-time and dead-time.
// Define TEMP_FAULT_EN to enable the sensor-fault state (out-of-range and stale sample detection).
module thermo_sequencer #(
  parameter logic [7:0]  TLOW_RST  = 8'd75,
  parameter logic [7:0]  THIGH_RST = 8'd90,
  parameter logic [7:0]  HYST_RST  = 8'd2,
  parameter int unsigned MIN_ON    = 8,
  parameter int unsigned DEAD_CYC  = 4,
  parameter int unsigned STALE_CYC = 64
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [7:0] Temp,
  input  logic       Temp_valid,
  input  logic       Cfg_we,
  input  logic [1:0] Cfg_sel,
  input  logic [7:0] Cfg_data,
  output logic       Cfg_ack,
  output logic       Cfg_err,
  output logic       Heat,
  output logic       Cool,
  output logic [2:0] State,
  output logic       Fault
);

  localparam int unsigned CntMaxV = (MIN_ON > DEAD_CYC) ? MIN_ON - 1 : DEAD_CYC - 1;
  localparam int unsigned CntW    = (CntMaxV > 0) ? $clog2(CntMaxV + 1) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CntMaxV);
  localparam logic [CntW-1:0] RunLast  = CntW'(MIN_ON - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYC - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHeat  = 3'd1,
    StCool  = 3'd2,
    StDead  = 3'd3,
    StFault = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      temp_q;
  logic            sample_seen_q;
  logic [7:0]      low_q, high_q, hyst_q;
  logic [7:0]      low_act_q, high_act_q, hyst_act_q;
  logic            ack_q, err_q;

  logic [7:0]      cfg_low, cfg_high;
  logic            cfg_reject;
  logic [8:0]      heat_sum, cool_diff;
  logic [8:0]      heat_off_lvl, cool_off_lvl;
  logic            run_done, dead_done;
  logic            heat_exit, cool_exit;

  // Sample capture
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      temp_q        <= 8'd0;
      sample_seen_q <= 1'b0;
    end else if (Temp_valid) begin
      temp_q        <= Temp;
      sample_seen_q <= 1'b1;
    end
  end

  // Config write check against the thresholds as they would be after the write
  always_comb begin
    cfg_low  = low_q;
    cfg_high = high_q;
    if (Cfg_sel == 2'd0) cfg_low  = Cfg_data;
    if (Cfg_sel == 2'd1) cfg_high = Cfg_data;
    cfg_reject = (Cfg_sel == 2'd3) || (cfg_low >= cfg_high);
  end

  // The *_act copies lag one cycle so a decision coinciding with a write uses old thresholds.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      low_q      <= TLOW_RST;
      high_q     <= THIGH_RST;
      hyst_q     <= HYST_RST;
      low_act_q  <= TLOW_RST;
      high_act_q <= THIGH_RST;
      hyst_act_q <= HYST_RST;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      low_act_q  <= low_q;
      high_act_q <= high_q;
      hyst_act_q <= hyst_q;
      ack_q      <= Cfg_we;
      err_q      <= Cfg_we & cfg_reject;
      if (Cfg_we && !cfg_reject) begin
        unique case (Cfg_sel)
          2'd0:    low_q  <= Cfg_data;
          2'd1:    high_q <= Cfg_data;
          2'd2:    hyst_q <= Cfg_data;
          default: ;
        endcase
      end
    end
  end

  // Hysteresis levels, saturated in 9 bits
  always_comb begin
    heat_sum     = {1'b0, low_act_q} + {1'b0, hyst_act_q};
    cool_diff    = {1'b0, high_act_q} - {1'b0, hyst_act_q};
    heat_off_lvl = heat_sum[8] ? 9'd255 : heat_sum;
    cool_off_lvl = cool_diff[8] ? 9'd0 : cool_diff;
    run_done     = (cnt_q >= RunLast);
    dead_done    = (cnt_q >= DeadLast);
    heat_exit    = ({1'b0, temp_q} >= heat_off_lvl) || (temp_q > high_act_q);
    cool_exit    = ({1'b0, temp_q} <= cool_off_lvl) || (temp_q < low_act_q);
  end

`ifdef TEMP_FAULT_EN
  localparam int unsigned StaleW = $clog2(STALE_CYC + 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYC);

  logic [StaleW-1:0] stale_cnt_q;
  logic              sample_new_q;
  logic              sample_bad, stale;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      stale_cnt_q  <= '0;
      sample_new_q <= 1'b0;
    end else begin
      sample_new_q <= Temp_valid;
      if (Temp_valid) begin
        stale_cnt_q <= '0;
      end else if (sample_seen_q && (stale_cnt_q != StaleMax)) begin
        stale_cnt_q <= stale_cnt_q + 1'b1;
      end
    end
  end

  assign sample_bad = sample_new_q && ((temp_q == 8'd0) || (temp_q == 8'd255));
  assign stale      = sample_seen_q && (stale_cnt_q == StaleMax);
`endif

  // State register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sample_seen_q) begin
          if (temp_q < low_act_q) begin
            state_d = StHeat;
          end else if (temp_q > high_act_q) begin
            state_d = StCool;
          end
        end
      end
      StHeat: if (run_done && heat_exit) state_d = StDead;
      StCool: if (run_done && cool_exit) state_d = StDead;
      StDead: if (dead_done) state_d = StIdle;
`ifdef TEMP_FAULT_EN
      StFault: if (sample_new_q) state_d = StDead;
`endif
      default: state_d = StIdle;
    endcase
`ifdef TEMP_FAULT_EN
    if (sample_bad || stale) state_d = StFault;
`endif
  end

  // Run/dead counter restarts on every state change and saturates otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs decode the state register only
  always_comb begin
    Heat    = (state_q == StHeat);
    Cool    = (state_q == StCool);
    State   = state_q;
    Cfg_ack = ack_q;
    Cfg_err = err_q;
`ifdef TEMP_FAULT_EN
    Fault   = (state_q == StFault);
`else
    Fault   = 1'b0;
`endif
  end

endmodule
